mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 75 +++++++
 tb/tb_mem_stage.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: pipeline memory stage with a data-memory handshake, a timeout abort and a registered writeback.
package mem_stage_pkg;
  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] write_data;
    logic        mem_write;
    logic        mem_read;
    logic        reg_write;
    logic [4:0]  rd;
  } ex_to_mem_s;
endpackage

module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  ex_to_mem_s  ex_to_mem,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata,
  input  logic        dm_ack,
  output logic        stall_mem,
  output logic [31:0] bp_mem,
  output logic        wb_reg_write,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        misalign_err,
  output logic        bus_err
);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t     state;
  logic [3:0] cnt;
  logic       is_mem, access, done, abort, load;
  // Request, stall and abort decode; ex_to_mem is held while stalled, so access stays valid in WAIT.
  always_comb begin
    is_mem    = ex_to_mem.mem_read | ex_to_mem.mem_write;
    access    = is_mem & (ex_to_mem.alu_result[1:0] == 2'b00);
    load      = ex_to_mem.mem_read & ~ex_to_mem.mem_write;
    dm_req    = rst_n & ((state == WAIT) | access);
    done      = dm_req & dm_ack;
    abort     = rst_n & (state == WAIT) & ~dm_ack & (cnt == 4'(TIMEOUT));
    stall_mem = dm_req & ~dm_ack & ~abort;
    dm_we     = ex_to_mem.mem_write;
    dm_addr   = ex_to_mem.alu_result;
    dm_wdata  = ex_to_mem.write_data;
    bp_mem    = ex_to_mem.alu_result;
  end
  // FSM, wait counter, writeback register and sticky error flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= 4'd0;
      wb_reg_write <= 1'b0;
      wb_rd        <= 5'd0;
      wb_data      <= 32'd0;
      misalign_err <= 1'b0;
      bus_err      <= 1'b0;
    end else begin
      state        <= stall_mem ? WAIT : IDLE;
      cnt          <= stall_mem ? cnt + 4'd1 : 4'd0;
      wb_reg_write <= ex_to_mem.reg_write & (done | ~is_mem);
      if (done | ~is_mem) begin
        wb_rd   <= ex_to_mem.rd;
        wb_data <= (done & load) ? dm_rdata : ex_to_mem.alu_result;
      end
      misalign_err <= misalign_err | (is_mem & ~access);
      bus_err      <= bus_err | abort;
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: table-driven scoreboard bench for mem_stage.
module tb_mem_stage;
  import mem_stage_pkg::*;
  typedef struct {
    ex_to_mem_s  op;
    int          dly;
    logic [31:0] rdata;
    logic        req;
    logic        we;
    int          stalls;
    logic        wbw;
    logic [4:0]  wrd;
    logic [31:0] wdata;
    logic        mis;
    logic        bus;
  } vec_t;
  logic        clk = 0, rst_n = 0, dm_req, dm_we, dm_ack = 0, stall_mem;
  logic        wb_reg_write, misalign_err, bus_err;
  logic [31:0] dm_addr, dm_wdata, dm_rdata = 0, bp_mem, wb_data;
  logic [4:0]  wb_rd;
  ex_to_mem_s  ex_to_mem = '0;
  int          total = 0, bad = 0;
  vec_t        sb[$];
  vec_t        vt[10];
  mem_stage #(.TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .ex_to_mem(ex_to_mem), .dm_req(dm_req), .dm_we(dm_we),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .stall_mem(stall_mem), .bp_mem(bp_mem), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
    .wb_data(wb_data), .misalign_err(misalign_err), .bus_err(bus_err)
  );
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic vec_t mk(input logic [31:0] alu, input logic [31:0] wd, input logic mw,
                              input logic mr, input logic rw, input logic [4:0] rd, input int dly,
                              input logic [31:0] rdata, input logic req, input logic we,
                              input int stalls, input logic wbw, input logic [4:0] wrd,
                              input logic [31:0] wdata, input logic mis, input logic bus);
    vec_t v;
    v.op = '{alu_result: alu, write_data: wd, mem_write: mw, mem_read: mr, reg_write: rw, rd: rd};
    v.dly = dly; v.rdata = rdata; v.req = req; v.we = we; v.stalls = stalls;
    v.wbw = wbw; v.wrd = wrd; v.wdata = wdata; v.mis = mis; v.bus = bus;
    return v;
  endfunction
  task automatic run_op(input vec_t v);
    int   cyc = 0, stalls = 0;
    logic st;
    vec_t e;
    sb.push_back(v);
    ex_to_mem = v.op;
    dm_rdata  = v.rdata;
    do begin
      dm_ack = (cyc == v.dly);
      #1;
      st = stall_mem;
      chk("bypass", bp_mem, v.op.alu_result);
      if (cyc == 0) begin
        chk("dm_req", dm_req, v.req);
        if (v.req) begin
          chk("dm_we", dm_we, v.we);
          chk("dm_addr", dm_addr, v.op.alu_result);
          chk("dm_wdata", dm_wdata, v.op.write_data);
        end
      end else begin
        chk("wait_req", dm_req, 1'b1);
        chk("wait_addr", dm_addr, v.op.alu_result);
        chk("bubble", wb_reg_write, 1'b0);
      end
      if (st) stalls++;
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end while (st && cyc < 40);
    dm_ack = 0;
    if (st) begin
      total++; bad++;
      $display("FAIL op_timeout: still stalled after %0d cycles, expected at most 40", cyc);
    end
    e = sb.pop_front();
    chk("stall_cycles", stalls, e.stalls);
    chk("wb_reg_write", wb_reg_write, e.wbw);
    chk("wb_rd", wb_rd, e.wrd);
    chk("wb_data", wb_data, e.wdata);
    chk("misalign_err", misalign_err, e.mis);
    chk("bus_err", bus_err, e.bus);
  endtask
  initial begin
    vt[0] = mk(32'h10, 0, 0, 0, 1, 5, -1, 0, 0, 0, 0, 1, 5, 32'h10, 0, 0);
    vt[1] = mk(32'h100, 0, 0, 1, 1, 7, 3, 32'hDEADBEEF, 1, 0, 3, 1, 7, 32'hDEADBEEF, 0, 0);
    vt[2] = mk(32'h200, 32'h55, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 32'h200, 0, 0);
    vt[3] = mk(32'h104, 0, 0, 1, 1, 3, 0, 32'h1234, 1, 0, 0, 1, 3, 32'h1234, 0, 0);
    vt[4] = mk(32'h102, 0, 0, 1, 1, 9, -1, 0, 0, 0, 0, 0, 3, 32'h1234, 1, 0);
    vt[5] = mk(32'hAB, 0, 0, 0, 1, 4, -1, 0, 0, 0, 0, 1, 4, 32'hAB, 1, 0);
    vt[6] = mk(32'h300, 0, 0, 1, 1, 6, -1, 0, 1, 0, 15, 0, 4, 32'hAB, 1, 1);
    vt[7] = mk(32'h77, 0, 0, 0, 1, 8, -1, 0, 0, 0, 0, 1, 8, 32'h77, 1, 1);
    vt[8] = mk(32'h40, 32'h99, 1, 1, 1, 2, 1, 32'hFFFF, 1, 1, 1, 1, 2, 32'h40, 1, 1);
    vt[9] = mk(32'h5, 0, 0, 0, 1, 1, 0, 32'hBAD, 0, 0, 0, 1, 1, 32'h5, 1, 1);
    ex_to_mem = '{alu_result: 32'h100, write_data: 0, mem_write: 0, mem_read: 1, reg_write: 1, rd: 7};
    @(negedge clk);
    #1;
    chk("rst_dm_req", dm_req, 1'b0);
    chk("rst_stall", stall_mem, 1'b0);
    @(posedge clk);
    @(negedge clk);
    chk("rst_wb_reg_write", wb_reg_write, 1'b0);
    chk("rst_wb_rd", wb_rd, 5'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_flags", {misalign_err, bus_err}, 2'b00);
    rst_n = 1;
    for (int i = 0; i < 10; i++) run_op(vt[i]);
    ex_to_mem = '{alu_result: 32'h500, write_data: 0, mem_write: 0, mem_read: 1, reg_write: 1, rd: 10};
    #1;
    chk("midwait_stall0", stall_mem, 1'b1);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("midwait_stall1", stall_mem, 1'b1);
    @(posedge clk);
    @(negedge clk);
    rst_n = 0;
    #1;
    chk("inrst_dm_req", dm_req, 1'b0);
    chk("inrst_stall", stall_mem, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    ex_to_mem = '0;
    dm_ack = 1;
    dm_rdata = 32'hCAFE;
    #1;
    chk("late_ack_req", dm_req, 1'b0);
    chk("late_ack_stall", stall_mem, 1'b0);
    chk("postrst_wb", {wb_reg_write, wb_rd, wb_data}, 38'd0);
    chk("postrst_flags", {misalign_err, bus_err}, 2'b00);
    @(posedge clk);
    @(negedge clk);
    dm_ack = 0;
    chk("late_ack_wbw", wb_reg_write, 1'b0);
    chk("late_ack_data", wb_data, 32'd0);
    run_op(vt[1]);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
